// File: rtl/register_file_64bit_pkg.sv
// Shared LEGv8 datapath constants used by the register file, ALU and control unit.
package register_file_64bit_pkg;

    localparam int LEGV8_DATA_WIDTH = 64;
    localparam int LEGV8_ADDR_WIDTH = 5;
    localparam int LEGV8_NUM_REGS   = 2 ** LEGV8_ADDR_WIDTH;
    localparam int LEGV8_ZERO_REG   = LEGV8_NUM_REGS - 1;

endpackage

// File: rtl/register_file_64bit_reg_read_port.sv
// One combinational read port: register select, XZR force to zero, and same-cycle write bypass.
module reg_read_port #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31,
    parameter int BYPASS     = 1
) (
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] sel,
    input  logic [DATA_WIDTH-1:0] regs [0:ZERO_REG-1],
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_SEL = ADDR_WIDTH'(ZERO_REG);

    logic bypass_hit;

    // A write to XZR is never forwarded, so the zero force takes priority over bypass.
    assign bypass_hit = (BYPASS != 0) && wr_en && (wr_sel == sel) && (wr_sel != ZERO_SEL);

    always_comb begin
        rd_data = '0;
        if (rst_n && (sel != ZERO_SEL)) begin
            if (bypass_hit) begin
                rd_data = wr_data;
            end else begin
                rd_data = regs[sel];
            end
        end
    end

endmodule

// File: rtl/register_file_64bit.sv
// LEGv8 register file: 31 storage registers plus hard-wired XZR, two combinational read ports, one write port.
module register_file_64bit
    import register_file_64bit_pkg::*;
#(
    parameter int DATA_WIDTH = LEGV8_DATA_WIDTH,
    parameter int ADDR_WIDTH = LEGV8_ADDR_WIDTH,
    parameter int ZERO_REG   = LEGV8_ZERO_REG,
    parameter int BYPASS     = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET_n,
    input  logic [ADDR_WIDTH-1:0] ReadSelect1,
    input  logic [ADDR_WIDTH-1:0] ReadSelect2,
    input  logic [ADDR_WIDTH-1:0] WriteSelect,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_SEL = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] regs_q [0:ZERO_REG-1];
    logic [DATA_WIDTH-1:0] regs_d [0:ZERO_REG-1];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (WriteSelect != ZERO_SEL)) begin
            regs_d[WriteSelect] = WriteData;
        end
    end

    // NOTE: this array is reset on purpose; the architecture requires every register to read zero
    // after reset, so it is built from flops rather than an unresettable RAM macro.
    always_ff @(posedge CLOCK) begin
        if (!RESET_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .ZERO_REG  (ZERO_REG),
        .BYPASS    (BYPASS)
    ) u_read_port1 (
        .rst_n  (RESET_n),
        .sel    (ReadSelect1),
        .regs   (regs_q),
        .wr_en  (RegWrite),
        .wr_sel (WriteSelect),
        .wr_data(WriteData),
        .rd_data(ReadData1)
    );

    reg_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .ZERO_REG  (ZERO_REG),
        .BYPASS    (BYPASS)
    ) u_read_port2 (
        .rst_n  (RESET_n),
        .sel    (ReadSelect2),
        .regs   (regs_q),
        .wr_en  (RegWrite),
        .wr_sel (WriteSelect),
        .wr_data(WriteData),
        .rd_data(ReadData2)
    );

endmodule
